// File: rtl/tri_pkg.sv
// Shared definitions for the triangle pipeline: coordinate width, bitmap size
// and the raster buffer state encoding.
package tri_pkg;

  localparam int unsigned CW  = 3;
  localparam int unsigned N   = 2 ** CW;
  localparam int unsigned PCW = 2 * CW + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/tri_bitmap_mem.sv
// N x N occupancy bitmap: synchronous clear, single-bit set returning the
// prior value, and one combinational row read port.
module tri_bitmap_mem
  import tri_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          set_we_i,
  input  logic [CW-1:0] set_x_i,
  input  logic [CW-1:0] set_y_i,
  output logic          set_prior_o,
  input  logic [CW-1:0] rd_y_i,
  output logic [N-1:0]  rd_row_o
);

  logic [N-1:0] rows_q [N];

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        rows_q[i] <= '0;
      end
    end else if (set_we_i) begin
      rows_q[set_y_i][set_x_i] <= 1'b1;
    end
  end

  assign set_prior_o = rows_q[set_y_i][set_x_i];
  assign rd_row_o    = rows_q[rd_y_i];

endmodule

// File: rtl/tri_raster_buf.sv
// Collects interior points from the triangle stage into a bitmap, counts
// distinct pixels, then drains the bitmap row by row over valid/ready.
module tri_raster_buf
  import tri_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           busy_in,
  input  logic           po_in,
  input  logic [CW-1:0]  xo_in,
  input  logic [CW-1:0]  yo_in,
  input  logic           row_ready,
  output logic           row_valid,
  output logic [CW-1:0]  row_idx,
  output logic [N-1:0]   row_data,
  output logic [PCW-1:0] pix_count,
  output logic           frame_done,
  output logic           dup_err,
  output logic           drop_err
);

  state_e         state_q, state_d;
  logic           busy_q;
  logic [PCW-1:0] pix_q, pix_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           dup_q, dup_d;
  logic           drop_q, drop_d;
  logic           clr, set_we, set_prior;
  logic           rise, fall;

  assign rise = busy_in & ~busy_q;
  assign fall = ~busy_in & busy_q;

  tri_bitmap_mem u_mem (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .set_we_i    (set_we),
    .set_x_i     (xo_in),
    .set_y_i     (yo_in),
    .set_prior_o (set_prior),
    .rd_y_i      (idx_q),
    .rd_row_o    (row_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      pix_q   <= '0;
      idx_q   <= '0;
      dup_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_in;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      dup_q   <= dup_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    dup_d   = dup_q;
    drop_d  = drop_q;
    clr     = 1'b0;
    set_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          clr     = 1'b1;
          pix_d   = '0;
          dup_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // A point arriving in the fall cycle is still written and counted.
        if (po_in) begin
          set_we = 1'b1;
          if (set_prior) dup_d = 1'b1;
          else           pix_d = pix_q + PCW'(1);
        end
        if (fall) begin
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rise) drop_d = 1'b1;
        if (row_ready) begin
          idx_d = idx_q + CW'(1);
          if (idx_q == CW'(N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (rise) drop_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_valid  = (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
  assign row_idx    = idx_q;
  assign pix_count  = pix_q;
  assign dup_err    = dup_q;
  assign drop_err   = drop_q;

endmodule

// File: tb/tb_tri_raster_buf.sv
// Directed bench for tri_raster_buf: capture, duplicates, backpressure,
// fall-cycle point, dropped frame start and mid-frame reset.
module tb_tri_raster_buf;

  logic       clk = 1'b0;
  logic       reset, busy_in, po_in, row_ready;
  logic [2:0] xo_in, yo_in;
  logic       row_valid, frame_done, dup_err, drop_err;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic [6:0] pix_count;

  int errors = 0;
  int checks = 0;

  logic [2:0] px [8];
  logic [2:0] py [8];
  logic [7:0] cap_rows [8];
  logic [7:0] exp_rows [8];
  int         cap_cnt;
  int         cap_order_err;

  always #5 clk = ~clk;

  tri_raster_buf dut (
    .clk        (clk),
    .reset      (reset),
    .busy_in    (busy_in),
    .po_in      (po_in),
    .xo_in      (xo_in),
    .yo_in      (yo_in),
    .row_ready  (row_ready),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .row_data   (row_data),
    .pix_count  (pix_count),
    .frame_done (frame_done),
    .dup_err    (dup_err),
    .drop_err   (drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise cycle, points on consecutive cycles, two quiet busy cycles, then fall.
  task automatic run_collect(input int n, input bit last_in_fall);
    busy_in = 1'b1;
    po_in   = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      if (last_in_fall && i == n - 1) break;
      po_in = 1'b1;
      xo_in = px[i];
      yo_in = py[i];
      tick();
    end
    po_in = 1'b0;
    tick();
    tick();
    busy_in = 1'b0;
    if (last_in_fall) begin
      po_in = 1'b1;
      xo_in = px[n-1];
      yo_in = py[n-1];
    end
    tick();
    po_in = 1'b0;
  endtask

  // Accept rows with ready held high; returns one cycle after the last transfer.
  task automatic drain_capture();
    logic [2:0] want;
    cap_cnt       = 0;
    cap_order_err = 0;
    row_ready     = 1'b1;
    for (int c = 0; c < 100 && cap_cnt < 8; c++) begin
      if (row_valid) begin
        want = cap_cnt[2:0];
        if (row_idx !== want) cap_order_err++;
        cap_rows[cap_cnt] = row_data;
        cap_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; busy_in = 1'b0; po_in = 1'b0; row_ready = 1'b0;
    xo_in = '0; yo_in = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({row_valid, row_idx, row_data, pix_count, frame_done, dup_err, drop_err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b idx=%0d data=%h pix=%0d done=%b dup=%b drop=%b, want all 0",
               row_valid, row_idx, row_data, pix_count, frame_done, dup_err, drop_err);
    end
    tick();
    checks++;
    if (row_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: row_valid=%b want 0", row_valid);
    end
  endtask

  task automatic test_basic(input string tag);
    px[0] = 3'd0; py[0] = 3'd0;
    px[1] = 3'd1; py[1] = 3'd0;
    px[2] = 3'd0; py[2] = 3'd1;
    run_collect(3, 1'b0);
    checks++;
    if (row_valid !== 1'b1 || row_idx !== 3'd0) begin
      errors++;
      $display("FAIL %s_first_valid: valid=%b idx=%0d want 1/0", tag, row_valid, row_idx);
    end
    checks++;
    if (pix_count !== 7'd3) begin
      errors++;
      $display("FAIL %s_pix: got %0d want 3", tag, pix_count);
    end
    drain_capture();
    exp_rows = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checks++;
    if (cap_cnt !== 8 || cap_order_err !== 0) begin
      errors++;
      $display("FAIL %s_transfers: count=%0d order_errs=%0d want 8/0", tag, cap_cnt, cap_order_err);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (cap_rows[r] !== exp_rows[r]) begin
        errors++;
        $display("FAIL %s_row%0d: got %h want %h", tag, r, cap_rows[r], exp_rows[r]);
      end
    end
    checks++;
    if (frame_done !== 1'b1 || row_valid !== 1'b0 || row_idx !== 3'd0) begin
      errors++;
      $display("FAIL %s_done: done=%b valid=%b idx=%0d want 1/0/0", tag, frame_done, row_valid, row_idx);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || dup_err !== 1'b0 || pix_count !== 7'd3) begin
      errors++;
      $display("FAIL %s_after: done=%b dup=%b pix=%0d want 0/0/3", tag, frame_done, dup_err, pix_count);
    end
  endtask

  task automatic test_duplicate();
    px[0] = 3'd2; py[0] = 3'd3;
    px[1] = 3'd2; py[1] = 3'd3;
    run_collect(2, 1'b0);
    checks++;
    if (pix_count !== 7'd1 || dup_err !== 1'b1) begin
      errors++;
      $display("FAIL dup_flags: pix=%0d dup=%b want 1/1", pix_count, dup_err);
    end
    drain_capture();
    checks++;
    if (cap_rows[3] !== 8'h04 || cap_rows[2] !== 8'h00) begin
      errors++;
      $display("FAIL dup_row3: row3=%h row2=%h want 04/00", cap_rows[3], cap_rows[2]);
    end
    tick();
    checks++;
    if (dup_err !== 1'b1) begin
      errors++;
      $display("FAIL dup_sticky: dup=%b want 1", dup_err);
    end
  endtask

  task automatic test_fall_point();
    px[0] = 3'd7; py[0] = 3'd7;
    run_collect(1, 1'b1);
    checks++;
    if (dup_err !== 1'b0) begin
      errors++;
      $display("FAIL fall_dup_cleared: dup=%b want 0", dup_err);
    end
    checks++;
    if (pix_count !== 7'd1) begin
      errors++;
      $display("FAIL fall_pix: got %0d want 1", pix_count);
    end
    drain_capture();
    checks++;
    if (cap_rows[7] !== 8'h80 || cap_rows[3] !== 8'h00) begin
      errors++;
      $display("FAIL fall_row7: row7=%h row3=%h want 80/00", cap_rows[7], cap_rows[3]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int         cnt;
    int         order_err;
    bit         stalled;
    logic [7:0] rows [8];
    logic [2:0] want;
    px[0] = 3'd5; py[0] = 3'd2;
    px[1] = 3'd6; py[1] = 3'd2;
    run_collect(2, 1'b0);
    cnt = 0; order_err = 0; stalled = 1'b0;
    row_ready = 1'b1;
    for (int c = 0; c < 100 && cnt < 8; c++) begin
      if (row_valid) begin
        if (row_idx == 3'd2 && !stalled) begin
          row_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            checks++;
            if (row_valid !== 1'b1 || row_idx !== 3'd2 || row_data !== 8'h60) begin
              errors++;
              $display("FAIL bp_stall%0d: valid=%b idx=%0d data=%h want 1/2/60",
                       s, row_valid, row_idx, row_data);
            end
          end
          row_ready = 1'b1;
          stalled   = 1'b1;
        end
        want = cnt[2:0];
        if (row_idx !== want) order_err++;
        rows[cnt] = row_data;
        cnt++;
      end
      tick();
    end
    checks++;
    if (cnt !== 8 || order_err !== 0 || !stalled) begin
      errors++;
      $display("FAIL bp_transfers: count=%0d order_errs=%0d stalled=%b want 8/0/1", cnt, order_err, stalled);
    end
    checks++;
    if (rows[2] !== 8'h60 || rows[1] !== 8'h00 || rows[3] !== 8'h00) begin
      errors++;
      $display("FAIL bp_rows: r1=%h r2=%h r3=%h want 00/60/00", rows[1], rows[2], rows[3]);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b want 1", frame_done);
    end
    tick();
  endtask

  task automatic test_drop();
    int         cnt;
    logic [7:0] rows [8];
    px[0] = 3'd4; py[0] = 3'd4;
    px[1] = 3'd1; py[1] = 3'd6;
    run_collect(2, 1'b0);
    cnt = 0;
    row_ready = 1'b1;
    for (int c = 0; c < 100 && cnt < 8; c++) begin
      busy_in = (row_valid && row_idx == 3'd4);
      if (row_valid) begin
        rows[cnt] = row_data;
        cnt++;
      end
      tick();
      busy_in = 1'b0;
      if (cnt == 5) begin
        checks++;
        if (drop_err !== 1'b1) begin
          errors++;
          $display("FAIL drop_flag: drop=%b want 1", drop_err);
        end
      end
    end
    checks++;
    if (cnt !== 8 || rows[4] !== 8'h10 || rows[6] !== 8'h02) begin
      errors++;
      $display("FAIL drop_rows: count=%0d r4=%h r6=%h want 8/10/02", cnt, rows[4], rows[6]);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL drop_done: done=%b want 1", frame_done);
    end
    // Points while idle must not be collected.
    po_in = 1'b1; xo_in = 3'd3; yo_in = 3'd3;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (row_valid !== 1'b0 || pix_count !== 7'd2 || drop_err !== 1'b1) begin
        errors++;
        $display("FAIL drop_idle%0d: valid=%b pix=%0d drop=%b want 0/2/1", c, row_valid, pix_count, drop_err);
      end
    end
    po_in = 1'b0;
  endtask

  task automatic test_mid_reset();
    busy_in = 1'b1;
    po_in   = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      po_in = 1'b1; xo_in = 3'(i); yo_in = 3'(i + 1);
      tick();
    end
    po_in = 1'b0;
    checks++;
    if (pix_count !== 7'd3) begin
      errors++;
      $display("FAIL mr_pre: pix=%0d want 3", pix_count);
    end
    reset   = 1'b1;
    busy_in = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (row_valid !== 1'b0 || pix_count !== 7'd0 || dup_err !== 1'b0 || drop_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mr_post: valid=%b pix=%0d dup=%b drop=%b done=%b want all 0",
               row_valid, pix_count, dup_err, drop_err, frame_done);
    end
    tick();
    checks++;
    if (row_valid !== 1'b0 || pix_count !== 7'd0) begin
      errors++;
      $display("FAIL mr_idle: valid=%b pix=%0d want 0/0", row_valid, pix_count);
    end
    test_basic("mr_basic");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_duplicate();
    test_fall_point();
    test_backpressure();
    test_drop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
